iagc_controller: RTL and testbench
==================================

# iagc_controller

Top-level sequencer of the IAGC core: owns the `i_iagc_status` state register consumed by `command_unit`. It forwards received command bytes to the decoder and acts on the decoded pulses. It runs the sample-capture, memory-clean and memory-dump sequences against the single-port capture RAM and the UART transmitter. It sits between the UART receiver/transmitter, `command_unit` and the sample memory.

## Interface
- `IAGC_STATUS_SIZE`, 4: status/state width.
- `CMD_PARAM_SIZE`, 4: command parameter width.
- `DATA_SIZE`, 8: command byte, sample and memory word width.
- `ADDR_SIZE`, 10: memory address width; depth 2^ADDR_SIZE.
- `INIT_CYCLES`, 16: cycles spent in INIT.

Ports (name, direction, width, meaning):
- `i_clock` in 1: single clock.
- `i_reset_n` in 1: asynchronous, active-low reset.
- `i_rx_valid` in 1: one-cycle strobe, a command byte has been received.
- `i_rx_data` in DATA_SIZE: received byte.
- `o_cmd` out DATA_SIZE: latched command byte, drives `command_unit`.
- `o_iagc_status` out IAGC_STATUS_SIZE: current state.
- `i_cmd_reset`, `i_cmd_sample`, `i_cmd_set_decim`, `i_cmd_clean_mem`, `i_cmd_dump_mem`, `i_cmd_set_mem` in 1 each: decoded pulses.
- `i_cmd_param` in CMD_PARAM_SIZE: decoded parameter.
- `i_sample_valid` in 1: ADC sample strobe.
- `i_sample_data` in DATA_SIZE: ADC sample.
- `o_mem_addr` out ADDR_SIZE: memory address.
- `o_mem_we` out 1: memory write enable.
- `o_mem_wdata` out DATA_SIZE: memory write data.
- `i_mem_rdata` in DATA_SIZE: read data, 1-cycle synchronous latency.
- `o_tx_valid` out 1: transmit byte valid.
- `o_tx_data` out DATA_SIZE: transmit byte.
- `i_tx_ready` in 1: transmitter ready.
- `o_error` out 1: one-cycle pulse on an unknown opcode.

## Operation
- **States (status codes):** RESET 0, INIT 1, IDLE 2, SAMPLE 3, CMD_PARSE 4, CMD_READ 5, CMD_ERROR 6, DUMP_MEM 7, CLEAN_MEM 8.
- **Registers:** `decim` (CMD_PARAM_SIZE) and `len_log2` (CMD_PARAM_SIZE).
  - `len_log2` reset value: ADDR_SIZE.
  - Capture length `len` = 2^min(len_log2, ADDR_SIZE) words.
- **RESET:**
  - Clears `decim` to 0.
  - Sets `len_log2` to ADDR_SIZE.
  - Next state: INIT.
- **INIT:** counts INIT_CYCLES cycles, then goes to IDLE.
- **IDLE:**
  - On `i_rx_valid`, latches `o_cmd <= i_rx_data` and goes to CMD_READ.
- **CMD_READ:** lasts 1 cycle, then goes to CMD_PARSE. The decode pulses are valid during CMD_PARSE.
- **CMD_PARSE dispatch:**
  - reset: to RESET.
  - sample: to SAMPLE.
  - set_decim: `decim <= param`, to IDLE.
  - clean_mem: to CLEAN_MEM.
  - dump_mem: to DUMP_MEM.
  - set_mem: `len_log2 <= param`, to IDLE.
  - no pulse: to CMD_ERROR.
- **CMD_ERROR:** asserts `o_error` for 1 cycle, then goes to IDLE.
- **SAMPLE:**
  - Address pointer and decimation counter start at 0.
  - On each `i_sample_valid`:
    - If `dcnt == decim`: write `i_sample_data` at the pointer, clear `dcnt`, increment the pointer.
    - Otherwise increment `dcnt`.
  - The effective rate is 1 sample in `decim+1`.
  - After the write at address `len-1`, go to IDLE.
- **CLEAN_MEM:**
  - Writes 0 to addresses 0 through 2^ADDR_SIZE−1, one per cycle.
  - Goes to IDLE after the last address.
  - Always clears the full depth, independent of `len`.
- **DUMP_MEM:** for each address 0 through `len-1`:
  - Issue the read (addr presented, `we=0`).
  - Next cycle: load `o_tx_data <= i_mem_rdata` and assert `o_tx_valid`.
  - Hold both until `o_tx_valid && i_tx_ready`, then advance.
  - After the last handshake, go to IDLE.
- **`i_rx_valid` outside IDLE:** the byte is dropped; no abort of a running sequence.
- **Memory port idle state:** `o_mem_we` is 0 in all states except the write cycles of SAMPLE and CLEAN_MEM.

## Timing
- **Reset values:**
  - `o_iagc_status` = RESET, `o_cmd` = 0, `o_mem_addr` = 0, `o_mem_we` = 0, `o_mem_wdata` = 0.
  - `o_tx_valid` = 0, `o_tx_data` = 0, `o_error` = 0.
- All outputs are registered. `o_iagc_status` equals the current state.
- **Command latency:** `i_rx_valid` at cycle N gives CMD_READ at N+1, CMD_PARSE at N+2, and the target state at N+3.
- **Sample writes:** `o_mem_we` pulses in the cycle after the accepted `i_sample_valid`. A strobe on every cycle with `decim=0` writes 1 word per cycle.
- **Clean:** occupies exactly 2^ADDR_SIZE cycles in CLEAN_MEM.
- **Dump:** 2 cycles minimum per byte. With `i_tx_ready` held high, the throughput is 1 byte per 2 cycles.
- **Async reset:** assertion mid-sequence forces all reset values immediately. A partial sample capture is lost; memory contents are not cleared.
- **Wrap-around:** the pointer never wraps because the sequence ends at `len-1`.
- **`len_log2 > ADDR_SIZE`:** saturates to full depth.

## Structure
- **Shared header `iagc_defs.vh`:**
  - Status codes, consumed by this block and `command_unit`.
  - Opcode constants: 0 reset, 1 sample, 2 set_decim, 3 clean_mem, 4 dump_mem, 5 set_mem.
- **Sub-module `iagc_dump_sequencer`:** read/handshake engine with address counter, rd-pending flag and tx hold register. It has a start/done interface; its memory outputs are muxed in the controller.

## Test plan
- **Reset/init:** release `i_reset_n` → status 0 for 1 cycle, 1 for 16 cycles, then 2; all outputs at reset values.
- **Bad opcode:** byte 0x9A in IDLE → status 5, 4, 6, 2 on consecutive cycles; `o_error` high exactly in the CMD_ERROR cycle.
- **Decimated capture:**
  - Stimulus: set_mem 0x52 (len 4), set_decim 0x22, then sample 0x10, then 12 strobes with data 1..12.
  - Response: writes 3, 6, 9, 12 at addresses 0..3, then IDLE.
- **Dump with backpressure:**
  - Stimulus: after the capture above, dump 0x40 with `i_tx_ready` low for 5 cycles per byte.
  - Response: `o_tx_data` 3, 6, 9, 12, each held stable while stalled.
- **Clean:** 0x30 with ADDR_SIZE=4 → 16 consecutive writes of 0 at addresses 0..15, then IDLE; a byte arriving mid-clean is dropped.
- **Async reset mid-SAMPLE:**
  - Stimulus: assert `i_reset_n` low mid-capture.
  - Response: `o_mem_we` 0 immediately, status 0; after release, `decim`=0 and `len`=2^ADDR_SIZE.

Source files
------------

// File: rtl/iagc_controller_pkg.sv
`default_nettype none
// iagc_controller_pkg: status codes, opcodes and capture-length helper shared by the IAGC core.
// Rev 1.0
package iagc_controller_pkg;

  typedef enum logic [3:0] {
    ST_RESET     = 4'd0,
    ST_INIT      = 4'd1,
    ST_IDLE      = 4'd2,
    ST_SAMPLE    = 4'd3,
    ST_CMD_PARSE = 4'd4,
    ST_CMD_READ  = 4'd5,
    ST_CMD_ERROR = 4'd6,
    ST_DUMP_MEM  = 4'd7,
    ST_CLEAN_MEM = 4'd8
  } status_e;

  localparam logic [3:0] OP_RESET     = 4'd0;
  localparam logic [3:0] OP_SAMPLE    = 4'd1;
  localparam logic [3:0] OP_SET_DECIM = 4'd2;
  localparam logic [3:0] OP_CLEAN_MEM = 4'd3;
  localparam logic [3:0] OP_DUMP_MEM  = 4'd4;
  localparam logic [3:0] OP_SET_MEM   = 4'd5;

  // Index of the last captured word; lengths beyond the memory depth saturate.
  function automatic int unsigned last_index(input int unsigned log2,
                                             input int unsigned depth_log2);
    int unsigned eff;
    eff = (log2 > depth_log2) ? depth_log2 : log2;
    return (32'd1 << eff) - 32'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/iagc_dump_sequencer.sv
`default_nettype none
// iagc_dump_sequencer: streams memory words 0..last_idx to the UART with ready/valid handshake.
// Rev 1.0
module iagc_dump_sequencer #(
  parameter int ADDR_SIZE = 10,
  parameter int DATA_SIZE = 8
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [ADDR_SIZE-1:0] last_idx,
  input  logic [DATA_SIZE-1:0] rdata,
  input  logic                 tx_ready,
  output logic [ADDR_SIZE-1:0] addr,
  output logic                 tx_valid,
  output logic [DATA_SIZE-1:0] tx_data,
  output logic                 done
);

  logic                 busy;
  logic                 rd_pend;
  logic [ADDR_SIZE-1:0] tx_idx;

  // The address advances as soon as a word is loaded, so the next read overlaps
  // the handshake of the current byte and sustains one byte per two cycles.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      busy     <= 1'b0;
      rd_pend  <= 1'b0;
      tx_valid <= 1'b0;
      tx_data  <= '0;
      addr     <= '0;
      tx_idx   <= '0;
    end else if (start) begin
      busy     <= 1'b1;
      rd_pend  <= 1'b0;
      tx_valid <= 1'b0;
      addr     <= '0;
    end else if (busy) begin
      if (tx_valid) begin
        if (tx_ready) begin
          tx_valid <= 1'b0;
          if (tx_idx == last_idx) begin
            busy <= 1'b0;
          end else begin
            rd_pend <= 1'b1;
          end
        end
      end else if (rd_pend) begin
        tx_data  <= rdata;
        tx_valid <= 1'b1;
        rd_pend  <= 1'b0;
        tx_idx   <= addr;
        addr     <= addr + 1'b1;
      end else begin
        rd_pend <= 1'b1;
      end
    end
  end

  assign done = busy && tx_valid && tx_ready && (tx_idx == last_idx);

endmodule
`default_nettype wire

// File: rtl/iagc_controller.sv
`default_nettype none
// iagc_controller: top-level IAGC sequencer for commands, sample capture, memory clean and dump.
// Rev 1.0
module iagc_controller
  import iagc_controller_pkg::*;
#(
  parameter int IAGC_STATUS_SIZE = 4,
  parameter int CMD_PARAM_SIZE   = 4,
  parameter int DATA_SIZE        = 8,
  parameter int ADDR_SIZE        = 10,
  parameter int INIT_CYCLES      = 16
) (
  input  logic                        i_clock,
  input  logic                        i_reset_n,
  input  logic                        i_rx_valid,
  input  logic [DATA_SIZE-1:0]        i_rx_data,
  output logic [DATA_SIZE-1:0]        o_cmd,
  output logic [IAGC_STATUS_SIZE-1:0] o_iagc_status,
  input  logic                        i_cmd_reset,
  input  logic                        i_cmd_sample,
  input  logic                        i_cmd_set_decim,
  input  logic                        i_cmd_clean_mem,
  input  logic                        i_cmd_dump_mem,
  input  logic                        i_cmd_set_mem,
  input  logic [CMD_PARAM_SIZE-1:0]   i_cmd_param,
  input  logic                        i_sample_valid,
  input  logic [DATA_SIZE-1:0]        i_sample_data,
  output logic [ADDR_SIZE-1:0]        o_mem_addr,
  output logic                        o_mem_we,
  output logic [DATA_SIZE-1:0]        o_mem_wdata,
  input  logic [DATA_SIZE-1:0]        i_mem_rdata,
  output logic                        o_tx_valid,
  output logic [DATA_SIZE-1:0]        o_tx_data,
  input  logic                        i_tx_ready,
  output logic                        o_error
);

  localparam int INIT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;

  status_e                   state, state_next;
  logic [DATA_SIZE-1:0]      cmd_next;
  logic [CMD_PARAM_SIZE-1:0] decim, decim_next;
  logic [CMD_PARAM_SIZE-1:0] len_log2, len_log2_next;
  logic [CMD_PARAM_SIZE-1:0] dcnt, dcnt_next;
  logic [INIT_W-1:0]         init_cnt, init_cnt_next;
  logic [ADDR_SIZE-1:0]      ptr, ptr_next;
  logic [ADDR_SIZE-1:0]      addr_reg, addr_next;
  logic [DATA_SIZE-1:0]      wdata_next;
  logic                      we_next, error_next;
  logic                      dump_start, dump_done;
  logic [ADDR_SIZE-1:0]      dump_addr, last_idx;

  assign last_idx      = ADDR_SIZE'(last_index(32'(len_log2), ADDR_SIZE));
  assign o_iagc_status = IAGC_STATUS_SIZE'(state);
  assign o_mem_addr    = (state == ST_DUMP_MEM) ? dump_addr : addr_reg;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) state <= ST_RESET;
    else            state <= state_next;
  end

  always_comb begin
    state_next    = state;
    cmd_next      = o_cmd;
    decim_next    = decim;
    len_log2_next = len_log2;
    dcnt_next     = dcnt;
    init_cnt_next = init_cnt;
    ptr_next      = ptr;
    addr_next     = addr_reg;
    wdata_next    = o_mem_wdata;
    we_next       = 1'b0;
    error_next    = 1'b0;
    dump_start    = 1'b0;
    case (state)
      ST_RESET: begin
        decim_next    = '0;
        len_log2_next = CMD_PARAM_SIZE'(ADDR_SIZE);
        init_cnt_next = '0;
        state_next    = ST_INIT;
      end
      ST_INIT: begin
        if (init_cnt == INIT_W'(INIT_CYCLES - 1)) state_next = ST_IDLE;
        else init_cnt_next = init_cnt + 1'b1;
      end
      ST_IDLE: begin
        if (i_rx_valid) begin
          cmd_next   = i_rx_data;
          state_next = ST_CMD_READ;
        end
      end
      ST_CMD_READ: state_next = ST_CMD_PARSE;
      ST_CMD_PARSE: begin
        if (i_cmd_reset) begin
          state_next = ST_RESET;
        end else if (i_cmd_sample) begin
          ptr_next   = '0;
          dcnt_next  = '0;
          state_next = ST_SAMPLE;
        end else if (i_cmd_set_decim) begin
          decim_next = i_cmd_param;
          state_next = ST_IDLE;
        end else if (i_cmd_clean_mem) begin
          we_next    = 1'b1;
          addr_next  = '0;
          wdata_next = '0;
          state_next = ST_CLEAN_MEM;
        end else if (i_cmd_dump_mem) begin
          dump_start = 1'b1;
          state_next = ST_DUMP_MEM;
        end else if (i_cmd_set_mem) begin
          len_log2_next = i_cmd_param;
          state_next    = ST_IDLE;
        end else begin
          error_next = 1'b1;
          state_next = ST_CMD_ERROR;
        end
      end
      ST_CMD_ERROR: state_next = ST_IDLE;
      ST_SAMPLE: begin
        // Stay through the final write cycle so the write lands inside SAMPLE.
        if (o_mem_we && addr_reg == last_idx) begin
          state_next = ST_IDLE;
        end else if (i_sample_valid) begin
          if (dcnt == decim) begin
            we_next    = 1'b1;
            addr_next  = ptr;
            wdata_next = i_sample_data;
            ptr_next   = ptr + 1'b1;
            dcnt_next  = '0;
          end else begin
            dcnt_next = dcnt + 1'b1;
          end
        end
      end
      ST_CLEAN_MEM: begin
        if (addr_reg == {ADDR_SIZE{1'b1}}) begin
          state_next = ST_IDLE;
        end else begin
          we_next   = 1'b1;
          addr_next = addr_reg + 1'b1;
        end
      end
      ST_DUMP_MEM: begin
        if (dump_done) state_next = ST_IDLE;
      end
      default: state_next = ST_RESET;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_cmd       <= '0;
      decim       <= '0;
      len_log2    <= CMD_PARAM_SIZE'(ADDR_SIZE);
      dcnt        <= '0;
      init_cnt    <= '0;
      ptr         <= '0;
      addr_reg    <= '0;
      o_mem_wdata <= '0;
      o_mem_we    <= 1'b0;
      o_error     <= 1'b0;
    end else begin
      o_cmd       <= cmd_next;
      decim       <= decim_next;
      len_log2    <= len_log2_next;
      dcnt        <= dcnt_next;
      init_cnt    <= init_cnt_next;
      ptr         <= ptr_next;
      addr_reg    <= addr_next;
      o_mem_wdata <= wdata_next;
      o_mem_we    <= we_next;
      o_error     <= error_next;
    end
  end

  iagc_dump_sequencer #(
    .ADDR_SIZE (ADDR_SIZE),
    .DATA_SIZE (DATA_SIZE)
  ) u_dump (
    .clock    (i_clock),
    .reset_n  (i_reset_n),
    .start    (dump_start),
    .last_idx (last_idx),
    .rdata    (i_mem_rdata),
    .tx_ready (i_tx_ready),
    .addr     (dump_addr),
    .tx_valid (o_tx_valid),
    .tx_data  (o_tx_data),
    .done     (dump_done)
  );

endmodule
`default_nettype wire

// File: tb/tb_iagc_controller.sv
`default_nettype none
// tb_iagc_controller: directed bench with a behavioural command decoder and single-port RAM.
// Rev 1.0
module tb_iagc_controller;

  localparam int SS = 4;
  localparam int PS = 4;
  localparam int DS = 8;
  localparam int AS = 4;
  localparam int IC = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rx_valid = 1'b0;
  logic [DS-1:0] rx_data = '0;
  logic [DS-1:0] cmd;
  logic [SS-1:0] status;
  logic          cmd_reset, cmd_sample, cmd_set_decim, cmd_clean_mem, cmd_dump_mem, cmd_set_mem;
  logic [PS-1:0] cmd_param;
  logic          sample_valid = 1'b0;
  logic [DS-1:0] sample_data = '0;
  logic [AS-1:0] mem_addr;
  logic          mem_we;
  logic [DS-1:0] mem_wdata;
  logic [DS-1:0] mem_rdata;
  logic          tx_valid;
  logic [DS-1:0] tx_data;
  logic          tx_ready = 1'b0;
  logic          error;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int bad_we  = 0;
  int bad_err = 0;

  logic [AS-1:0] wr_a[$];
  logic [DS-1:0] wr_d[$];
  int            wr_c[$];
  logic [DS-1:0] mem [1<<AS];

  always #5 clk = ~clk;

  iagc_controller #(
    .IAGC_STATUS_SIZE (SS),
    .CMD_PARAM_SIZE   (PS),
    .DATA_SIZE        (DS),
    .ADDR_SIZE        (AS),
    .INIT_CYCLES      (IC)
  ) dut (
    .i_clock         (clk),
    .i_reset_n       (rst_n),
    .i_rx_valid      (rx_valid),
    .i_rx_data       (rx_data),
    .o_cmd           (cmd),
    .o_iagc_status   (status),
    .i_cmd_reset     (cmd_reset),
    .i_cmd_sample    (cmd_sample),
    .i_cmd_set_decim (cmd_set_decim),
    .i_cmd_clean_mem (cmd_clean_mem),
    .i_cmd_dump_mem  (cmd_dump_mem),
    .i_cmd_set_mem   (cmd_set_mem),
    .i_cmd_param     (cmd_param),
    .i_sample_valid  (sample_valid),
    .i_sample_data   (sample_data),
    .o_mem_addr      (mem_addr),
    .o_mem_we        (mem_we),
    .o_mem_wdata     (mem_wdata),
    .i_mem_rdata     (mem_rdata),
    .o_tx_valid      (tx_valid),
    .o_tx_data       (tx_data),
    .i_tx_ready      (tx_ready),
    .o_error         (error)
  );

  // Decoder model: opcode in the upper nibble, parameter in the lower, pulses only in CMD_PARSE.
  logic parse;
  assign parse         = (status == 4'd4);
  assign cmd_reset     = parse && (cmd[7:4] == 4'd0);
  assign cmd_sample    = parse && (cmd[7:4] == 4'd1);
  assign cmd_set_decim = parse && (cmd[7:4] == 4'd2);
  assign cmd_clean_mem = parse && (cmd[7:4] == 4'd3);
  assign cmd_dump_mem  = parse && (cmd[7:4] == 4'd4);
  assign cmd_set_mem   = parse && (cmd[7:4] == 4'd5);
  assign cmd_param     = cmd[3:0];

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_n && mem_we) begin
      wr_a.push_back(mem_addr);
      wr_d.push_back(mem_wdata);
      wr_c.push_back(cyc);
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1 && mem_we === 1'b1 && status != 4'd3 && status != 4'd8) bad_we++;
    if (rst_n === 1'b1 && error === 1'b1 && status != 4'd6) bad_err++;
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    int w;
    w = 0;
    while (status !== 4'd2 && w < bound) begin
      @(negedge clk);
      w++;
    end
  endtask

  task automatic clear_log;
    wr_a.delete();
    wr_d.delete();
    wr_c.delete();
  endtask

  task automatic test_reset;
    logic [3:0] exp;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if (status !== 4'd0 || cmd !== 8'h00 || mem_addr !== 4'd0 || mem_we !== 1'b0 ||
        mem_wdata !== 8'h00 || tx_valid !== 1'b0 || tx_data !== 8'h00 || error !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_values: status=%0d cmd=%h addr=%0d we=%b wdata=%h txv=%b txd=%h err=%b, required all 0",
               status, cmd, mem_addr, mem_we, mem_wdata, tx_valid, tx_data, error);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 18; i++) begin
      if (i > 0) @(negedge clk);
      else @(negedge clk);
      exp = (i == 0) ? 4'd0 : (i <= 16) ? 4'd1 : 4'd2;
      n_tests++;
      if (status !== exp) begin
        n_fail++;
        $display("FAIL init_seq[%0d]: status=%0d required %0d", i, status, exp);
      end
    end
  endtask

  task automatic test_bad_opcode;
    send_byte(8'h9A);
    n_tests++;
    if (status !== 4'd5 || cmd !== 8'h9A || error !== 1'b0) begin
      n_fail++;
      $display("FAIL bad_op_read: status=%0d cmd=%h err=%b required 5 9a 0", status, cmd, error);
    end
    @(negedge clk);
    n_tests++;
    if (status !== 4'd4 || error !== 1'b0) begin
      n_fail++;
      $display("FAIL bad_op_parse: status=%0d err=%b required 4 0", status, error);
    end
    @(negedge clk);
    n_tests++;
    if (status !== 4'd6 || error !== 1'b1) begin
      n_fail++;
      $display("FAIL bad_op_error: status=%0d err=%b required 6 1", status, error);
    end
    @(negedge clk);
    n_tests++;
    if (status !== 4'd2 || error !== 1'b0) begin
      n_fail++;
      $display("FAIL bad_op_idle: status=%0d err=%b required 2 0", status, error);
    end
  endtask

  task automatic test_capture;
    send_byte(8'h52);
    repeat (2) @(negedge clk);
    send_byte(8'h22);
    repeat (2) @(negedge clk);
    n_tests++;
    if (status !== 4'd2) begin
      n_fail++;
      $display("FAIL setup_idle: status=%0d required 2", status);
    end
    send_byte(8'h10);
    repeat (2) @(negedge clk);
    n_tests++;
    if (status !== 4'd3) begin
      n_fail++;
      $display("FAIL sample_entry: status=%0d required 3", status);
    end
    clear_log();
    for (int i = 1; i <= 12; i++) begin
      sample_valid = 1'b1;
      sample_data  = 8'(i);
      @(negedge clk);
    end
    sample_valid = 1'b0;
    n_tests++;
    if (mem_we !== 1'b1 || mem_addr !== 4'd3 || mem_wdata !== 8'd12 || status !== 4'd3) begin
      n_fail++;
      $display("FAIL last_write: we=%b addr=%0d data=%0d status=%0d required 1 3 12 3",
               mem_we, mem_addr, mem_wdata, status);
    end
    @(negedge clk);
    n_tests++;
    if (status !== 4'd2 || mem_we !== 1'b0) begin
      n_fail++;
      $display("FAIL capture_done: status=%0d we=%b required 2 0", status, mem_we);
    end
    n_tests++;
    if (wr_a.size() != 4) begin
      n_fail++;
      $display("FAIL capture_count: writes=%0d required 4", wr_a.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_tests++;
        if (wr_a[i] !== 4'(i) || wr_d[i] !== 8'(3 * (i + 1))) begin
          n_fail++;
          $display("FAIL capture_word[%0d]: addr=%0d data=%0d required %0d %0d",
                   i, wr_a[i], wr_d[i], i, 3 * (i + 1));
        end
      end
    end
  endtask

  task automatic test_dump_backpressure;
    logic [7:0] exp;
    int w;
    tx_ready = 1'b0;
    send_byte(8'h40);
    repeat (2) @(negedge clk);
    n_tests++;
    if (status !== 4'd7 || mem_we !== 1'b0 || mem_addr !== 4'd0) begin
      n_fail++;
      $display("FAIL dump_entry: status=%0d we=%b addr=%0d required 7 0 0", status, mem_we, mem_addr);
    end
    for (int b = 0; b < 4; b++) begin
      exp = 8'(3 * (b + 1));
      w = 0;
      while (tx_valid !== 1'b1 && w < 6) begin
        @(negedge clk);
        w++;
      end
      n_tests++;
      if (tx_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL dump_valid_timeout[%0d]: tx_valid=%b required 1", b, tx_valid);
      end
      for (int k = 0; k < 6; k++) begin
        if (k == 5) tx_ready = 1'b1;
        n_tests++;
        if (tx_valid !== 1'b1 || tx_data !== exp) begin
          n_fail++;
          $display("FAIL dump_hold[%0d.%0d]: valid=%b data=%0d required 1 %0d", b, k, tx_valid, tx_data, exp);
        end
        @(negedge clk);
      end
      tx_ready = 1'b0;
      n_tests++;
      if (tx_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL dump_release[%0d]: valid=%b required 0", b, tx_valid);
      end
    end
    n_tests++;
    if (status !== 4'd2) begin
      n_fail++;
      $display("FAIL dump_done: status=%0d required 2", status);
    end
  endtask

  task automatic test_clean;
    send_byte(8'h30);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      n_tests++;
      if (status !== 4'd8 || mem_we !== 1'b1 || mem_addr !== 4'(i) || mem_wdata !== 8'h00) begin
        n_fail++;
        $display("FAIL clean_word[%0d]: status=%0d we=%b addr=%0d data=%h required 8 1 %0d 00",
                 i, status, mem_we, mem_addr, mem_wdata, i);
      end
      if (i == 5) begin
        rx_valid = 1'b1;
        rx_data  = 8'h9A;
      end
      if (i == 6) rx_valid = 1'b0;
      @(negedge clk);
    end
    n_tests++;
    if (status !== 4'd2 || mem_we !== 1'b0) begin
      n_fail++;
      $display("FAIL clean_done: status=%0d we=%b required 2 0", status, mem_we);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_tests++;
      if (status !== 4'd2 || error !== 1'b0) begin
        n_fail++;
        $display("FAIL clean_drop[%0d]: status=%0d err=%b required 2 0", i, status, error);
      end
    end
  endtask

  task automatic test_async_reset;
    send_byte(8'h10);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      sample_valid = 1'b1;
      sample_data  = 8'(8'hA0 + i);
      @(negedge clk);
    end
    sample_valid = 1'b0;
    n_tests++;
    if (mem_we !== 1'b1 || status !== 4'd3) begin
      n_fail++;
      $display("FAIL pre_reset_write: we=%b status=%0d required 1 3", mem_we, status);
    end
    #1 rst_n = 1'b0;
    #1;
    n_tests++;
    if (mem_we !== 1'b0 || status !== 4'd0 || mem_addr !== 4'd0 || mem_wdata !== 8'h00 || cmd !== 8'h00) begin
      n_fail++;
      $display("FAIL async_reset: we=%b status=%0d addr=%0d wdata=%h cmd=%h required 0 0 0 00 00",
               mem_we, status, mem_addr, mem_wdata, cmd);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    wait_idle(20);
    n_tests++;
    if (status !== 4'd2) begin
      n_fail++;
      $display("FAIL reinit_idle: status=%0d required 2", status);
    end
    send_byte(8'h10);
    repeat (2) @(negedge clk);
    clear_log();
    for (int i = 0; i < 16; i++) begin
      sample_valid = 1'b1;
      sample_data  = 8'(8'h40 + i);
      @(negedge clk);
    end
    sample_valid = 1'b0;
    wait_idle(4);
    n_tests++;
    if (status !== 4'd2 || wr_a.size() != 16) begin
      n_fail++;
      $display("FAIL full_capture: status=%0d writes=%0d required 2 16", status, wr_a.size());
    end else begin
      for (int i = 0; i < 16; i++) begin
        n_tests++;
        if (wr_a[i] !== 4'(i) || wr_d[i] !== 8'(8'h40 + i) || wr_c[i] != wr_c[0] + i) begin
          n_fail++;
          $display("FAIL full_word[%0d]: addr=%0d data=%h cyc=%0d required %0d %h %0d",
                   i, wr_a[i], wr_d[i], wr_c[i], i, 8'h40 + i, wr_c[0] + i);
        end
      end
    end
  endtask

  task automatic test_port_idle;
    n_tests++;
    if (bad_we != 0 || bad_err != 0) begin
      n_fail++;
      $display("FAIL stray_pulses: we_outside=%0d err_outside=%0d required 0 0", bad_we, bad_err);
    end
  endtask

  initial begin
    test_reset();
    test_bad_opcode();
    test_capture();
    test_dump_backpressure();
    test_clean();
    test_async_reset();
    test_port_idle();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
